// File: rtl/sw_mem_writer.sv
// Switch/key driven RAM writer: stages a 32-bit word from the switches and commits it
// through the testbench RAM port while the CPU is held, holding WEN for HOLD_CYCLES.
module sw_mem_writer #(
    parameter int ADDR_W      = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int DEBOUNCE    = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        enable,
    input  logic [15:0] sw,
    input  logic        key_lo_n,
    input  logic        key_hi_n,
    input  logic        key_addr_n,
    input  logic        key_wr_n,
    output logic        tb_ctrl,
    output logic        wen,
    output logic [31:0] addr,
    output logic [31:0] store,
    output logic        busy,
    output logic [31:0] staged,
    output logic [15:0] wr_count
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    logic [3:0]        key_raw;
    logic [3:0]        press;
    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] sw_aligned;

    assign key_raw    = {key_wr_n, key_addr_n, key_hi_n, key_lo_n};
    assign sw_aligned = {sw[ADDR_W-1:2], 2'b00};
    assign addr       = 32'(addr_reg);

    // Per key: 2-flop synchronizer, then a level filter that emits one pulse per accepted press.
    for (genvar k = 0; k < 4; k++) begin : g_key
        logic          sync1, sync2, deb, pulse;
        logic [CW-1:0] cnt;

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
                deb   <= 1'b1;
                pulse <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= key_raw[k];
                sync2 <= sync1;
                pulse <= 1'b0;
                if (sync2 != deb) begin
                    if (cnt == CW'(DEBOUNCE - 1)) begin
                        deb   <= sync2;
                        cnt   <= '0;
                        pulse <= ~sync2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign press[k] = pulse;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            hold_cnt <= '0;
            addr_reg <= '0;
            staged   <= '0;
            wr_count <= '0;
            tb_ctrl  <= 1'b0;
            wen      <= 1'b0;
            busy     <= 1'b0;
            store    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Priority wr > addr > hi > lo; lower-priority pulses in the same cycle are dropped.
                    if (press[3]) begin
                        if (enable) begin
                            state    <= WRITE;
                            hold_cnt <= '0;
                            tb_ctrl  <= 1'b1;
                            wen      <= 1'b1;
                            busy     <= 1'b1;
                            store    <= staged;
                        end
                    end else if (press[2]) begin
                        addr_reg <= sw_aligned;
                    end else if (press[1]) begin
                        staged[31:16] <= sw;
                    end else if (press[0]) begin
                        staged[15:0] <= sw;
                    end
                end
                WRITE: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        state <= DONE;
                        wen   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    tb_ctrl  <= 1'b0;
                    busy     <= 1'b0;
                    store    <= '0;
                    addr_reg <= addr_reg + ADDR_W'(4);
                    wr_count <= wr_count + 16'd1;
                end
                default: begin
                    state   <= IDLE;
                    tb_ctrl <= 1'b0;
                    wen     <= 1'b0;
                    busy    <= 1'b0;
                    store   <= '0;
                end
            endcase
        end
    end

endmodule
